// File: rtl/fifo_rr_arbiter_if.sv
// Bundle between the arbiter and its sources/sink: FIFO status, pop strobes,
// merged output stream and status flags.
interface fifo_rr_arbiter_if #(
  parameter int W = 6,
  parameter int N = 4
);
  logic [N-1:0]   fifo_empty;
  logic [N-1:0]   valid_in;
  logic [N*W-1:0] data_in;
  logic           pause;
  logic [N-1:0]   fifo_rd;
  logic [W-1:0]   data_out;
  logic           valid_out;
  logic [1:0]     grant;
  logic           busy;
  logic           err;

  modport master (
    input  fifo_empty, valid_in, data_in, pause,
    output fifo_rd, data_out, valid_out, grant, busy, err
  );

  modport slave (
    output fifo_empty, valid_in, data_in, pause,
    input  fifo_rd, data_out, valid_out, grant, busy, err
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain of four source FIFOs onto one registered stream, with a
// per-grant burst limit, downstream pause and a read-latency-matched output stage.
module fifo_rr_arbiter #(
  parameter int W     = 6,
  parameter int N     = 4,
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              RESET_L,
  fifo_rr_arbiter_if.master bus
);
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t       state_reg;
  logic [1:0]   grant_reg;
  logic [1:0]   last_reg;
  logic [3:0]   cnt_reg;
  logic         rd_reg;
  logic [1:0]   idx_reg;
  logic         valid_reg;
  logic [W-1:0] data_reg;
  logic         err_reg;

  logic [N-1:0] rd_vec;
  logic [W-1:0] slice [N];
  logic         pop;
  logic         grant_end;
  logic         word_ok;
  logic [1:0]   pick_base;
  logic [1:0]   pick_idx;
  logic         pick_ok;

  for (genvar gi = 0; gi < N; gi++) begin : g_src
    assign rd_vec[gi] = (state_reg == GRANT) && (grant_reg == 2'(gi)) &&
                        !bus.fifo_empty[gi] && !bus.pause;
    assign slice[gi]  = bus.data_in[gi*W +: W];
  end

  assign pop       = |rd_vec;
  assign grant_end = (pop && (cnt_reg == 4'(BURST - 1))) || bus.fifo_empty[grant_reg];
  assign word_ok   = bus.valid_in[idx_reg];
  // While granted the search starts after the current source, otherwise after the last one served.
  assign pick_base = (state_reg == GRANT) ? grant_reg : last_reg;

  // Scan downwards so the nearest source after pick_base wins; k == N wraps back to pick_base itself.
  always_comb begin
    logic [1:0] cand;
    pick_ok  = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = N; k >= 1; k--) begin
      cand = pick_base + 2'(k);
      if (!bus.fifo_empty[cand]) begin
        pick_ok  = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      last_reg  <= 2'(N - 1);
      cnt_reg   <= '0;
      rd_reg    <= 1'b0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      rd_reg    <= pop;
      idx_reg   <= grant_reg;
      valid_reg <= rd_reg && word_ok;
      if (rd_reg && word_ok) begin
        data_reg <= slice[idx_reg];
      end
      if (rd_reg && !word_ok) begin
        err_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (!bus.pause && pick_ok) begin
            state_reg <= GRANT;
            grant_reg <= pick_idx;
            cnt_reg   <= '0;
          end
        end
        GRANT: begin
          if (grant_end) begin
            last_reg <= grant_reg;
            if (!bus.pause && pick_ok) begin
              grant_reg <= pick_idx;
              cnt_reg   <= '0;
            end else begin
              state_reg <= IDLE;
            end
          end else if (pop) begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.fifo_rd   = rd_vec;
  assign bus.data_out  = data_reg;
  assign bus.valid_out = valid_reg;
  assign bus.grant     = grant_reg;
  assign bus.busy      = (state_reg == GRANT);
  assign bus.err       = err_reg;
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench: emulated source FIFOs, a queue-based arbitration model checked
// every cycle, and hand-computed pop/output sequences for each scenario.
module tb_fifo_rr_arbiter;
  localparam int W     = 6;
  localparam int N     = 4;
  localparam int BURST = 2;

  typedef struct {
    int         due;
    bit         ok;
    logic [5:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic RESET_L;

  fifo_rr_arbiter_if #(.W(W), .N(N)) bus ();

  fifo_rr_arbiter #(.W(W), .N(N), .BURST(BURST)) dut (
    .clk     (clk),
    .RESET_L (RESET_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [5:0]   q [N][$];
  ent_t         sched [$];
  int           pop_log [$];
  int           out_log [$];
  int           out_cyc [$];
  int           exp_seq [$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_err = 0;
  logic [N-1:0] pop_vec = '0;
  bit           pop_wh = 1'b0;
  int           wh_req = 0;
  int           wh_ack = 0;

  bit           m_busy;
  int           m_grant;
  int           m_last;
  int           m_cnt;
  bit           m_valid;
  int           m_data;
  bit           m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    if (v == '0) return -1;
    if ($countones(v) != 1) return -2;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -2;
  endfunction

  // Round-robin choice: nearest non-empty source after p, wrapping round to p itself.
  function automatic int pick(input int p);
    for (int k = 1; k <= N; k++) begin
      if (!bus.fifo_empty[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic set_empty();
    logic [N-1:0] e;
    for (int i = 0; i < N; i++) e[i] = (q[i].size() == 0);
    bus.fifo_empty = e;
  endtask

  task automatic push(input int s, input logic [5:0] d);
    q[s].push_back(d);
  endtask

  task automatic source_update();
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    v = '0;
    d = bus.data_in;
    for (int i = 0; i < N; i++) begin
      if (pop_vec[i] && q[i].size() > 0) begin
        d[i*W +: W] = q[i].pop_front();
        v[i] = !pop_wh;
      end
    end
    bus.valid_in = v;
    bus.data_in  = d;
    set_empty();
  endtask

  task automatic model_and_compare();
    logic [N-1:0] m_rd;
    ent_t         e;
    int           p;
    bit           done;
    if (!RESET_L) begin
      m_busy = 0; m_grant = 0; m_last = N - 1; m_cnt = 0;
      m_valid = 0; m_data = 0; m_err = 0;
      sched.delete();
    end else begin
      m_valid = 0;
      while (sched.size() > 0 && sched[0].due <= cyc) begin
        if (sched[0].ok) begin
          m_valid = 1;
          m_data  = int'(sched[0].data);
        end else begin
          m_err = 1;
        end
        void'(sched.pop_front());
      end
    end
    m_rd = '0;
    if (RESET_L && m_busy && !bus.fifo_empty[m_grant] && !bus.pause) m_rd[m_grant] = 1'b1;

    check("fifo_rd",   32'(bus.fifo_rd),   32'(m_rd));
    check("grant",     32'(bus.grant),     32'(m_grant));
    check("busy",      32'(bus.busy),      32'(m_busy));
    check("valid_out", 32'(bus.valid_out), 32'(m_valid));
    check("data_out",  32'(bus.data_out),  32'(m_data));
    check("err",       32'(bus.err),       32'(m_err));

    pop_log.push_back(onehot_idx(bus.fifo_rd));
    if (bus.valid_out === 1'b1) begin
      out_log.push_back(int'(bus.data_out));
      out_cyc.push_back(cyc);
      $display("cycle %0d: word %02h from source %0d", cyc, bus.data_out, dut.idx_reg);
    end

    pop_vec = bus.fifo_rd;
    pop_wh  = (wh_req != wh_ack);

    if (RESET_L) begin
      if (m_rd != '0) begin
        e.due  = cyc + 2;
        e.ok   = !pop_wh;
        e.data = q[m_grant][0];
        sched.push_back(e);
        if (pop_wh) wh_ack = wh_req;
      end
      if (!m_busy) begin
        p = pick(m_last);
        if (!bus.pause && p >= 0) begin
          m_busy = 1; m_grant = p; m_cnt = 0;
        end
      end else begin
        if (m_rd != '0) m_cnt++;
        done = ((m_rd != '0) && m_cnt == BURST) || bus.fifo_empty[m_grant];
        if (done) begin
          m_last = m_grant;
          p = pick(m_grant);
          if (!bus.pause && p >= 0) begin
            m_grant = p; m_cnt = 0;
          end else begin
            m_busy = 0;
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic tick(input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      model_and_compare();
      @(posedge clk);
      #1;
      source_update();
      #1;
    end
  endtask

  task automatic check_pops(input string name, input int m);
    for (int k = 0; k < exp_seq.size(); k++) check(name, 32'(pop_log[m + k]), 32'(exp_seq[k]));
  endtask

  task automatic check_outs(input string name, input int mc);
    check({name, "_count"}, 32'(out_log.size() - mc), 32'(exp_seq.size()));
    for (int k = 0; k < exp_seq.size(); k++) check(name, 32'(out_log[mc + k]), 32'(exp_seq[k]));
  endtask

  initial begin
    int m, mc, c0;
    RESET_L        = 1'b0;
    bus.pause      = 1'b0;
    bus.valid_in   = '0;
    bus.data_in    = '0;
    bus.fifo_empty = '1;
    tick(2);
    check("rst_fifo_rd",   32'(bus.fifo_rd),   32'h0);
    check("rst_valid_out", 32'(bus.valid_out), 32'h0);
    check("rst_data_out",  32'(bus.data_out),  32'h0);
    check("rst_grant",     32'(bus.grant),     32'h0);
    check("rst_busy",      32'(bus.busy),      32'h0);
    RESET_L = 1'b1;
    tick(2);

    // All four sources loaded, burst of 2 each, starting at source 0.
    m = pop_log.size(); mc = out_log.size();
    for (int s = 0; s < N; s++) begin
      for (int k = 0; k < ((s == 0) ? 4 : 2); k++) push(s, 6'(s * 16 + k + 1));
    end
    set_empty();
    tick(16);
    exp_seq = '{-1, 0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    check_pops("rr_pop_seq", m);
    exp_seq = '{'h01, 'h02, 'h11, 'h12, 'h21, 'h22, 'h31, 'h32, 'h03, 'h04};
    check_outs("rr_out_seq", mc);

    // Source 0 alone with three words: back-to-back pops and outputs.
    m = pop_log.size(); mc = out_log.size(); c0 = cyc;
    push(0, 6'h12); push(0, 6'h24); push(0, 6'h36);
    set_empty();
    tick(10);
    exp_seq = '{-1, 0, 0, 0, -1};
    check_pops("src0_pop_seq", m);
    exp_seq = '{'h12, 'h24, 'h36};
    check_outs("src0_out_seq", mc);
    for (int k = 0; k < 3; k++) check("src0_out_cycle", 32'(out_cyc[mc + k] - c0), 32'(3 + k));
    check("src0_idle", 32'(bus.busy), 32'h0);

    // Source 1 streaming, pause raised after the first pop for three cycles.
    m = pop_log.size(); mc = out_log.size();
    for (int k = 0; k < 6; k++) push(1, 6'(8 + k));
    set_empty();
    tick(2);
    bus.pause = 1'b1;
    tick(3);
    check("pause_inflight_count", 32'(out_log.size() - mc), 32'd1);
    bus.pause = 1'b0;
    tick(12);
    exp_seq = '{-1, 1, -1, -1, -1, 1, 1, 1, 1, 1};
    check_pops("pause_pop_seq", m);
    exp_seq = '{8, 9, 10, 11, 12, 13};
    check_outs("pause_out_seq", mc);

    // Source 2 has one word, source 3 five; source 2 runs dry and source 3 follows.
    m = pop_log.size(); mc = out_log.size();
    push(2, 6'h2c);
    for (int k = 0; k < 5; k++) push(3, 6'(6'h31 + k));
    set_empty();
    tick(12);
    exp_seq = '{-1, 2, -1, 3, 3, 3, 3, 3, -1};
    check_pops("regrant_pop_seq", m);
    exp_seq = '{'h2c, 'h31, 'h32, 'h33, 'h34, 'h35};
    check_outs("regrant_out_seq", mc);

    // First pop of source 0 gets no valid_in back.
    mc = out_log.size();
    check("err_before", 32'(bus.err), 32'h0);
    push(0, 6'h2a); push(0, 6'h15);
    set_empty();
    wh_req++;
    tick(8);
    check("err_sticky", 32'(bus.err), 32'h1);
    exp_seq = '{'h15};
    check_outs("err_out_seq", mc);

    // Asynchronous reset in the middle of a source 3 burst.
    push(3, 6'h30); push(3, 6'h31); push(3, 6'h32);
    push(3, 6'h33); push(3, 6'h34); push(3, 6'h35);
    set_empty();
    tick(4);
    #1;
    RESET_L = 1'b0;
    #1;
    check("async_fifo_rd",   32'(bus.fifo_rd),   32'h0);
    check("async_valid_out", 32'(bus.valid_out), 32'h0);
    check("async_data_out",  32'(bus.data_out),  32'h0);
    check("async_err",       32'(bus.err),       32'h0);
    check("async_busy",      32'(bus.busy),      32'h0);
    check("async_grant",     32'(bus.grant),     32'h0);
    tick(2);
    RESET_L = 1'b1;
    mc = out_log.size();
    tick(10);
    exp_seq = '{'h33, 'h34, 'h35};
    check_outs("post_reset_out_seq", mc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
